// File: rtl/edram_arb.sv
// Two-requester round-robin arbiter in front of edram_ss with bounded bursts.
// Read data is steered back to the issuing requester by an RD_LAT-deep ID pipe.
module edram_arb #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 128,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wbe,
  output logic                m0_gnt,
  output logic                m0_rsp_valid,
  output logic [DATA_W-1:0]   m0_rsp_data,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wbe,
  output logic                m1_gnt,
  output logic                m1_rsp_valid,
  output logic [DATA_W-1:0]   m1_rsp_data,

  output logic                edram_rvalid,
  output logic [ADDR_W-1:0]   edram_raddr,
  input  logic                edram_rready,
  input  logic [DATA_W-1:0]   edram_rdata,

  output logic                edram_wvalid,
  output logic [ADDR_W-1:0]   edram_waddr,
  output logic [DATA_W-1:0]   edram_wdata,
  output logic [DATA_W/8-1:0] edram_wbe,
  input  logic                edram_wready
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic       owner;
  logic [3:0] burst_cnt;
  logic       hold_vld;
  logic       hold_id;
  logic [1:0] id_pipe [RD_LAT];

  logic sel_any;
  logic sel;
  logic sel_we;
  logic gnt;
  logic rd_gnt;

  // burst_cnt==0 means no burst in progress, so contention hands over to ~owner;
  // with owner resetting to 1 this gives m0 the first contended slot.
  always_comb begin
    sel_any = m0_req | m1_req;
    sel     = m1_req;
    if (hold_vld && (hold_id ? m1_req : m0_req))
      sel = hold_id;
    else if (m0_req && m1_req)
      sel = (burst_cnt != 4'd0 && burst_cnt < MAX_B) ? owner : ~owner;
    sel_we = sel ? m1_we : m0_we;
    gnt    = rst_n && sel_any && (sel_we ? edram_wready : edram_rready);
    rd_gnt = gnt && !sel_we;
  end

  assign m0_gnt       = gnt && !sel;
  assign m1_gnt       = gnt && sel;

  assign edram_rvalid = rst_n && sel_any && !sel_we;
  assign edram_wvalid = rst_n && sel_any && sel_we;
  assign edram_raddr  = sel ? m1_addr  : m0_addr;
  assign edram_waddr  = sel ? m1_addr  : m0_addr;
  assign edram_wdata  = sel ? m1_wdata : m0_wdata;
  assign edram_wbe    = sel ? m1_wbe   : m0_wbe;

  assign m0_rsp_valid = id_pipe[RD_LAT-1][0];
  assign m1_rsp_valid = id_pipe[RD_LAT-1][1];
  assign m0_rsp_data  = edram_rdata;
  assign m1_rsp_data  = edram_rdata;

  // hold_* pins a stalled selection so a late-arriving requester cannot steal it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b1;
      burst_cnt <= 4'd0;
      hold_vld  <= 1'b0;
      hold_id   <= 1'b0;
    end else if (gnt) begin
      if (sel == owner)
        burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
      else
        burst_cnt <= 4'd1;
      owner    <= sel;
      hold_vld <= 1'b0;
    end else if (!sel_any) begin
      burst_cnt <= 4'd0;
      hold_vld  <= 1'b0;
    end else begin
      hold_vld <= 1'b1;
      hold_id  <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) id_pipe[k] <= 2'b00;
    end else begin
      id_pipe[0] <= {rd_gnt & sel, rd_gnt & ~sel};
      for (int k = 1; k < RD_LAT; k++) id_pipe[k] <= id_pipe[k-1];
    end
  end

endmodule
